tone_scheduler: RTL and testbench

TONE_SCHEDULER -- requirements
Module: tone_scheduler

---
 rtl/tone_pkg.sv | 37 +++
 rtl/tone_scheduler_key_encoder.sv | 23 ++
 rtl/tone_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_tone_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// tone_pkg -- shared definitions for the tone scheduler.
//   state_t            : scheduler states
//   NOTE_REST          : note code meaning "silence"
//   ROM_AW             : song ROM address width
//   NOTE_*/DUR_* bits  : field positions inside a song ROM word {note, dur}
//   NOTE_C4..NOTE_C5   : note indices presented to the tone generator
package tone_pkg;

  localparam int unsigned ROM_AW = 6;

  localparam logic [3:0] NOTE_REST = 4'hF;

  localparam int unsigned NOTE_MSB = 7;
  localparam int unsigned NOTE_LSB = 4;
  localparam int unsigned DUR_MSB  = 3;
  localparam int unsigned DUR_LSB  = 0;

  localparam logic [3:0] NOTE_C4 = 4'd0;
  localparam logic [3:0] NOTE_D4 = 4'd1;
  localparam logic [3:0] NOTE_E4 = 4'd2;
  localparam logic [3:0] NOTE_F4 = 4'd3;
  localparam logic [3:0] NOTE_G4 = 4'd4;
  localparam logic [3:0] NOTE_A4 = 4'd5;
  localparam logic [3:0] NOTE_B4 = 4'd6;
  localparam logic [3:0] NOTE_C5 = 4'd7;

  typedef enum logic [2:0] {
    IDLE,
    MANUAL,
    FETCH,
    LOAD,
    PLAY,
    GAP,
    DONE
  } state_t;

endpackage

// File: rtl/tone_scheduler_key_encoder.sv
// key_encoder -- combinational 8-to-4 priority encoder for the note keys.
//   sw  [7:0] : debounced keys, sw[7] = C4 ... sw[0] = C5
//   idx [3:0] : index of the lowest-pitch pressed key (sw[7] -> 0, sw[0] -> 7),
//               NOTE_REST when no key is pressed
//   any       : at least one key pressed
module key_encoder
  import tone_pkg::*;
(
  input  logic [7:0] sw,
  output logic [3:0] idx,
  output logic       any
);

  always_comb begin
    idx = NOTE_REST;
    any = |sw;
    // Scan upward so the highest-numbered (lowest-pitch) set bit wins.
    for (int unsigned i = 0; i < 8; i++) begin
      if (sw[i]) idx = 4'(7 - i);
    end
  end

endmodule

// File: rtl/tone_scheduler.sv
// tone_scheduler -- manual key player and ROM-driven song autoplayer.
//   CLK        : system clock, rising edge
//   RESET      : asynchronous active-low reset
//   tick       : one-cycle beat strobe (duration time base)
//   sw         : debounced keys, sw[7]..sw[0] = C4..C5
//   mode_auto  : 1 = autoplay, 0 = manual
//   start      : one-cycle pulse starting autoplay from IDLE
//   rom_addr   : song ROM address
//   rom_data   : {note, dur}, valid the cycle after rom_addr changes
//   note_idx   : 0..7 = C4..C5, 4'hF = rest
//   note_valid : tone generator enable
//   busy       : high in every state but IDLE
//   song_done  : one-cycle pulse at the end of a song
// Optional build macro KEY_OVERRIDE_EN: keys pressed during PLAY/GAP pause the
// song and play the keys; the song resumes where it was once keys are released.
// Without the macro the keys are ignored during autoplay.
module tone_scheduler
  import tone_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              tick,
  input  logic [7:0]        sw,
  input  logic              mode_auto,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [3:0]        note_idx,
  output logic              note_valid,
  output logic              busy,
  output logic              song_done
);

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] cur_note;
  logic [3:0] key_idx;
  logic       key_any;
  logic [3:0] rom_note;
  logic [3:0] rom_dur;
  logic       ovr;
  logic       abort;

  key_encoder u_key_encoder (
    .sw  (sw),
    .idx (key_idx),
    .any (key_any)
  );

  assign rom_note = rom_data[NOTE_MSB:NOTE_LSB];
  assign rom_dur  = rom_data[DUR_MSB:DUR_LSB];

`ifdef KEY_OVERRIDE_EN
  assign ovr = key_any;
`else
  assign ovr = 1'b0;
`endif

  // Leaving auto mode cancels a song from any state that is still running it.
  assign abort = !mode_auto &&
                 (state == FETCH || state == LOAD || state == PLAY || state == GAP);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      rom_addr   <= '0;
      note_idx   <= NOTE_REST;
      note_valid <= 1'b0;
      busy       <= 1'b0;
      song_done  <= 1'b0;
      cnt        <= '0;
      cur_note   <= NOTE_REST;
    end else begin
      song_done <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        rom_addr   <= '0;
        note_idx   <= NOTE_REST;
        note_valid <= 1'b0;
        busy       <= 1'b0;
        cnt        <= '0;
      end else begin
        case (state)
          IDLE: begin
            rom_addr <= '0;
            if (mode_auto) begin
              if (start) begin
                state <= FETCH;
                busy  <= 1'b1;
              end
            end else if (key_any) begin
              state      <= MANUAL;
              busy       <= 1'b1;
              note_idx   <= key_idx;
              note_valid <= 1'b1;
            end
          end
          MANUAL: begin
            if (key_any) begin
              note_idx   <= key_idx;
              note_valid <= 1'b1;
            end else begin
              state      <= IDLE;
              busy       <= 1'b0;
              note_idx   <= NOTE_REST;
              note_valid <= 1'b0;
            end
          end
          FETCH: state <= LOAD;
          LOAD: begin
            if (rom_dur == 4'd0) begin
              state     <= DONE;
              song_done <= 1'b1;
            end else begin
              state      <= PLAY;
              cnt        <= rom_dur;
              cur_note   <= rom_note;
              note_idx   <= rom_note;
              // Codes 8..15 are all silent; only 0..7 drive the generator.
              note_valid <= ~rom_note[3];
            end
          end
          PLAY: begin
            if (ovr) begin
              note_idx   <= key_idx;
              note_valid <= 1'b1;
            end else begin
              // Restores the song note after an override is released.
              note_idx   <= cur_note;
              note_valid <= ~cur_note[3];
              if (tick) begin
                if (cnt == 4'd1) begin
                  state      <= GAP;
                  cnt        <= '0;
                  note_idx   <= NOTE_REST;
                  note_valid <= 1'b0;
                end else begin
                  cnt <= cnt - 4'd1;
                end
              end
            end
          end
          GAP: begin
            if (ovr) begin
              note_idx   <= key_idx;
              note_valid <= 1'b1;
            end else begin
              note_idx   <= NOTE_REST;
              note_valid <= 1'b0;
              if (tick) begin
                if (rom_addr == '1) begin
                  state     <= DONE;
                  song_done <= 1'b1;
                end else begin
                  rom_addr <= rom_addr + ROM_AW'(1);
                  state    <= FETCH;
                end
              end
            end
          end
          DONE: begin
            state      <= IDLE;
            busy       <= 1'b0;
            rom_addr   <= '0;
            note_idx   <= NOTE_REST;
            note_valid <= 1'b0;
          end
          default: begin
            state      <= IDLE;
            busy       <= 1'b0;
            rom_addr   <= '0;
            note_idx   <= NOTE_REST;
            note_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_scheduler.sv
// tb_tone_scheduler -- self-checking bench for tone_scheduler.
// Songs are expanded into the list of notes expected at each beat; the bench
// samples the outputs in every tick cycle and compares against that list.
// Build with KEY_OVERRIDE_EN defined to also exercise the key override.
module tb_tone_scheduler;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       tick;
  logic [7:0] sw;
  logic       mode_auto;
  logic       start;
  logic [5:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] note_idx;
  logic       note_valid;
  logic       busy;
  logic       song_done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rom [64];

  typedef struct {
    logic       play;
    logic       valid;
    logic [3:0] idx;
  } samp_t;

  samp_t exp_q[$];

  tone_scheduler dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .tick       (tick),
    .sw         (sw),
    .mode_auto  (mode_auto),
    .start      (start),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .note_idx   (note_idx),
    .note_valid (note_valid),
    .busy       (busy),
    .song_done  (song_done)
  );

  always #5 CLK = ~CLK;

  // Synchronous song ROM: data for an address is available one cycle later.
  always @(posedge CLK) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Lowest-pitch key = highest set bit; C4 (bit 7) is index 0.
  function automatic logic [3:0] ref_key(input logic [7:0] k);
    for (int i = 7; i >= 0; i--) begin
      if (k[i]) return 4'(7 - i);
    end
    return 4'hF;
  endfunction

  task automatic clear_rom();
    for (int a = 0; a < 64; a++) rom[a] = 8'h00;
  endtask

  // Each entry sounds for dur beats, followed by one silent beat.
  task automatic build_expect();
    logic [7:0] e;
    samp_t      s;
    exp_q.delete();
    for (int a = 0; a < 64; a++) begin
      e = rom[a];
      if (e[3:0] == 4'd0) break;
      for (int k = 0; k < int'(e[3:0]); k++) begin
        s.play  = 1'b1;
        s.valid = (e[7:4] < 4'd8);
        s.idx   = e[7:4];
        exp_q.push_back(s);
      end
      s.play  = 1'b0;
      s.valid = 1'b0;
      s.idx   = 4'hF;
      exp_q.push_back(s);
    end
  endtask

  task automatic done_window(input string tag, input int exp_dones);
    int dones;
    dones = 0;
    repeat (12) begin
      if (song_done) dones++;
      cyc();
    end
    check({tag, "_done_pulses"}, dones, exp_dones);
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_addr_end"}, rom_addr, 6'd0);
    check({tag, "_valid_end"}, note_valid, 1'b0);
  endtask

  task automatic run_song(input string tag, input int p, input bit noisy);
    build_expect();
    mode_auto = 1'b1;
    start     = 1'b1;
    cyc();
    start = 1'b0;
    check({tag, "_busy_start"}, busy, 1'b1);
    check({tag, "_addr_start"}, rom_addr, 6'd0);
    foreach (exp_q[i]) begin
      repeat (p - 1) begin
        if (noisy) sw = 8'($urandom);
        cyc();
      end
      tick = 1'b1;
      check($sformatf("%s_valid_beat%0d", tag, i), note_valid, exp_q[i].valid);
      if (exp_q[i].play)
        check($sformatf("%s_idx_beat%0d", tag, i), note_idx, exp_q[i].idx);
      cyc();
      tick = 1'b0;
    end
    sw = 8'h00;
    done_window(tag, 1);
  endtask

  task automatic random_song(input int len);
    int r;
    clear_rom();
    for (int a = 0; a < len; a++) begin
      r = int'($urandom_range(0, 9));
      if (r < 8)       rom[a][7:4] = 4'(r);
      else if (r == 8) rom[a][7:4] = 4'hF;
      else             rom[a][7:4] = 4'($urandom_range(8, 14));
      rom[a][3:0] = 4'($urandom_range(1, 3));
    end
  endtask

  initial begin
    logic [7:0] k;
    int         dones;
    RESET     = 1'b0;
    tick      = 1'b0;
    sw        = 8'h00;
    mode_auto = 1'b0;
    start     = 1'b0;
    clear_rom();
    #12;
    check("rst_addr", rom_addr, 6'd0);
    check("rst_idx", note_idx, 4'hF);
    check("rst_valid", note_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", song_done, 1'b0);
    cyc();
    RESET = 1'b1;
    cyc();

    // Manual directed
    sw = 8'b0010_0000; cyc();
    check("man_e_idx", note_idx, 4'd2);
    check("man_e_valid", note_valid, 1'b1);
    check("man_e_busy", busy, 1'b1);
    sw = 8'b1010_0000; cyc();
    check("man_c_idx", note_idx, 4'd0);
    sw = 8'h00; cyc();
    check("man_off_valid", note_valid, 1'b0);
    check("man_off_busy", busy, 1'b0);

    // Manual random, key changes tracked every cycle
    for (int i = 0; i < 20; i++) begin
      k  = 8'($urandom_range(1, 255));
      sw = k;
      cyc();
      check($sformatf("man_rand_idx%0d", i), note_idx, ref_key(k));
      check($sformatf("man_rand_valid%0d", i), note_valid, 1'b1);
    end
    sw = 8'h00; cyc();
    check("man_rand_busy_end", busy, 1'b0);

    // Auto mode wins over keys in IDLE
    mode_auto = 1'b1;
    sw        = 8'h81;
    cyc(); cyc();
    check("auto_keys_busy", busy, 1'b0);
    check("auto_keys_valid", note_valid, 1'b0);
    sw = 8'h00;

    // Basic autoplay
    clear_rom();
    rom[0] = 8'h02; rom[1] = 8'h41; rom[2] = 8'h00;
    run_song("basic", 4, 1'b0);

    // Rest entry
    clear_rom();
    rom[0] = 8'hF3; rom[1] = 8'h00;
    run_song("rest", 5, 1'b0);

    // Random songs; in the default build keys are noise that must be ignored
    for (int s = 0; s < 3; s++) begin
      random_song(int'($urandom_range(1, 6)));
`ifdef KEY_OVERRIDE_EN
      run_song($sformatf("rand%0d", s), int'($urandom_range(3, 6)), 1'b0);
`else
      run_song($sformatf("rand%0d", s), int'($urandom_range(3, 6)), 1'b1);
`endif
    end

    // ROM end: 64 non-zero entries, no terminator
    for (int a = 0; a < 64; a++) rom[a] = {4'($urandom_range(0, 7)), 4'd1};
    run_song("romend", 3, 1'b0);

    // Abort mid-PLAY
    clear_rom();
    rom[0] = 8'h05; rom[1] = 8'h00;
    mode_auto = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    check("abort_play_valid", note_valid, 1'b1);
    mode_auto = 1'b0;
    cyc();
    check("abort_busy", busy, 1'b0);
    check("abort_valid", note_valid, 1'b0);
    dones = 0;
    repeat (6) begin
      if (song_done) dones++;
      cyc();
    end
    check("abort_no_done", dones, 0);

    // Reset mid-PLAY
    mode_auto = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    check("rstmid_play_valid", note_valid, 1'b1);
    #2;
    RESET = 1'b0;
    #1;
    check("rstmid_addr", rom_addr, 6'd0);
    check("rstmid_idx", note_idx, 4'hF);
    check("rstmid_valid", note_valid, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_done", song_done, 1'b0);
    cyc();
    RESET = 1'b1;
    cyc();
    check("rstmid_idle", busy, 1'b0);

`ifdef KEY_OVERRIDE_EN
    // Key override mid-song
    clear_rom();
    rom[0] = 8'h23; rom[1] = 8'h00;
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    tick = 1'b1;
    check("ovr_pre_idx", note_idx, 4'd2);
    cyc(); tick = 1'b0;
    sw = 8'h01;
    cyc();
    check("ovr_key_idx", note_idx, 4'd7);
    for (int t = 0; t < 5; t++) begin
      repeat (3) cyc();
      tick = 1'b1;
      check($sformatf("ovr_hold_idx%0d", t), note_idx, 4'd7);
      check($sformatf("ovr_hold_valid%0d", t), note_valid, 1'b1);
      cyc(); tick = 1'b0;
    end
    sw = 8'h00;
    cyc();
    check("ovr_resume_idx", note_idx, 4'd2);
    for (int t = 0; t < 2; t++) begin
      repeat (3) cyc();
      tick = 1'b1;
      check($sformatf("ovr_rest_idx%0d", t), note_idx, 4'd2);
      check($sformatf("ovr_rest_valid%0d", t), note_valid, 1'b1);
      cyc(); tick = 1'b0;
    end
    repeat (3) cyc();
    tick = 1'b1;
    check("ovr_gap_valid", note_valid, 1'b0);
    cyc(); tick = 1'b0;
    done_window("ovr", 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
